// File: rtl/dpe_scan_pkg.sv
// Shared types and helpers for the scan-chain SRAM loader.
package dpe_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    REQ,
    RD_WAIT,
    DONE
  } loader_state_t;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 8;

  function automatic int frame_bits(input int word_w, input int addr_w);
    return word_w + addr_w + 1;
  endfunction

  localparam int DEF_FRAME_BITS = frame_bits(DEF_WORD_W, DEF_ADDR_W);

  // Frame layout as shifted in, LSB first: data, then addr, then cmd on top.
  typedef struct packed {
    logic                  cmd;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_WORD_W-1:0] data;
  } scan_frame_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin with one-cycle rise and fall pulses.
module sync_edge_det #(
  parameter int SYNC_FF = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_FF-1:0] chain;
  logic               prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= SYNC_FF'({chain, async_in});
      prev  <= chain[SYNC_FF-1];
    end
  end

  assign rise = chain[SYNC_FF-1] & ~prev;
  assign fall = ~chain[SYNC_FF-1] & prev;

endmodule

// File: rtl/scan_sram_loader.sv
// Turns scan-chain frames into SRAM write/read requests, with read-back on scanOut
// and an all-ones sentinel frame that ends initialisation.
module scan_sram_loader
  import dpe_scan_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LANES   = 1,
  parameter int SYNC_FF = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SC_CLK,
  input  logic              SC_EN,
  input  logic [LANES-1:0]  scanIn,
  output logic [LANES-1:0]  scanOut,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              init_done,
  output logic              frame_err
);

  localparam int FB    = frame_bits(WORD_W, ADDR_W);
  localparam int NS    = FB / LANES;
  localparam int CNT_W = $clog2(NS + 2);
  localparam int OUT_W = ((WORD_W + LANES - 1) / LANES) * LANES;
  localparam logic [CNT_W-1:0] CNT_NS  = CNT_W'(NS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NS + 1);

  typedef struct packed {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } frame_t;

  generate
    if ((FB % LANES) != 0) begin : g_lane_check
      $error("scan_sram_loader: frame bits must be a multiple of LANES");
    end
  endgenerate

  loader_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [FB-1:0]    in_sr;
  logic [FB-1:0]    in_next;
  logic [OUT_W-1:0] out_sr;
  logic             en_hi;
  logic             en_lvl;
  logic             sc_strobe;
  logic             sc_clk_fall;
  logic             sc_en_rise;
  logic             sc_en_fall;
  frame_t           frame;

  sync_edge_det #(.SYNC_FF(SYNC_FF)) u_sync_clk (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (SC_CLK),
    .rise     (sc_strobe),
    .fall     (sc_clk_fall)
  );

  sync_edge_det #(.SYNC_FF(SYNC_FF)) u_sync_en (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (SC_EN),
    .rise     (sc_en_rise),
    .fall     (sc_en_fall)
  );

  // New lanes enter at the top so the first strobe ends up in the LSBs.
  generate
    if (FB > LANES) begin : g_shift
      assign in_next = {scanIn, in_sr[FB-1:LANES]};
    end else begin : g_load
      assign in_next = scanIn;
    end
  endgenerate

  // The scan clock only ever matters on its rising edge; its falling edge is a no-op.
  assign en_lvl  = sc_en_rise | (en_hi & ~sc_en_fall & ~(sc_clk_fall & 1'b0));
  assign frame   = in_sr;
  assign scanOut = out_sr[LANES-1:0];

  // Main loader FSM; every output is registered here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      en_hi     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      init_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      en_hi <= en_lvl;

      if (sc_strobe && en_lvl && (state == IDLE || state == SHIFT)) begin
        out_sr <= out_sr >> LANES;
      end

      case (state)
        IDLE: begin
          if (en_lvl) begin
            state <= SHIFT;
            if (sc_strobe) begin
              in_sr <= in_next;
              cnt   <= CNT_W'(1);
            end else begin
              cnt <= '0;
            end
          end
        end

        SHIFT: begin
          if (sc_strobe) begin
            in_sr <= in_next;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
          if (sc_en_fall) state <= CHECK;
        end

        CHECK: begin
          if (sc_en_rise) frame_err <= 1'b1;
          if (cnt != CNT_NS) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (&in_sr) begin
            init_done <= 1'b1;
            state     <= DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= frame.cmd;
            mem_addr  <= frame.addr;
            mem_wdata <= frame.data;
            state     <= REQ;
          end
        end

        REQ: begin
          if (sc_en_rise) frame_err <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? IDLE : RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (sc_en_rise) frame_err <= 1'b1;
          if (mem_rvalid) begin
            out_sr <= OUT_W'(mem_rdata);
            state  <= IDLE;
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sram_loader.sv
// Directed bench: a LANES=1 loader (64-bit words) and a LANES=4 loader (11-bit addresses).
module tb_scan_sram_loader;

  localparam int A_WORD_W = 64;
  localparam int A_ADDR_W = 8;
  localparam int B_WORD_W = 32;
  localparam int B_ADDR_W = 11;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  logic                a_sc_clk = 1'b0;
  logic                a_sc_en = 1'b0;
  logic [0:0]          a_scan_in = '0;
  logic [0:0]          a_scan_out;
  logic                a_mem_req;
  logic                a_mem_we;
  logic [A_ADDR_W-1:0] a_mem_addr;
  logic [A_WORD_W-1:0] a_mem_wdata;
  logic                a_mem_gnt = 1'b0;
  logic                a_mem_rvalid = 1'b0;
  logic [A_WORD_W-1:0] a_mem_rdata = '0;
  logic                a_init_done;
  logic                a_frame_err;

  logic                b_sc_clk = 1'b0;
  logic                b_sc_en = 1'b0;
  logic [3:0]          b_scan_in = '0;
  logic [3:0]          b_scan_out;
  logic                b_mem_req;
  logic                b_mem_we;
  logic [B_ADDR_W-1:0] b_mem_addr;
  logic [B_WORD_W-1:0] b_mem_wdata;
  logic                b_mem_gnt = 1'b0;
  logic                b_mem_rvalid = 1'b0;
  logic [B_WORD_W-1:0] b_mem_rdata = '0;
  logic                b_init_done;
  logic                b_frame_err;

  int checks = 0;
  int errors = 0;
  int a_hs = 0;
  int a_req_cycles = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (a_mem_req) a_req_cycles <= a_req_cycles + 1;
    if (a_mem_req && a_mem_gnt) a_hs <= a_hs + 1;
  end

  scan_sram_loader #(.WORD_W(A_WORD_W), .ADDR_W(A_ADDR_W), .LANES(1), .SYNC_FF(2)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .SC_CLK(a_sc_clk), .SC_EN(a_sc_en),
    .scanIn(a_scan_in), .scanOut(a_scan_out),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_gnt(a_mem_gnt), .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
    .init_done(a_init_done), .frame_err(a_frame_err)
  );

  scan_sram_loader #(.WORD_W(B_WORD_W), .ADDR_W(B_ADDR_W), .LANES(4), .SYNC_FF(2)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .SC_CLK(b_sc_clk), .SC_EN(b_sc_en),
    .scanIn(b_scan_in), .scanOut(b_scan_out),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
    .init_done(b_init_done), .frame_err(b_frame_err)
  );

  task automatic a_shift(input logic [72:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      a_scan_in = frame[i];
      a_sc_clk = 1'b0;
      repeat (3) @(negedge CLK);
      a_sc_clk = 1'b1;
      repeat (3) @(negedge CLK);
    end
    a_sc_clk = 1'b0;
  endtask

  task automatic a_send(input logic [72:0] frame, input int n);
    a_sc_en = 1'b1;
    repeat (3) @(negedge CLK);
    a_shift(frame, n);
    a_sc_en = 1'b0;
  endtask

  task automatic a_wait_req(input string name);
    int t = 0;
    while (a_mem_req !== 1'b1 && t < 40) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (a_mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: mem_req got %b want 1 within 40 cycles", name, a_mem_req);
    end
  endtask

  task automatic a_grant();
    a_mem_gnt = 1'b1;
    @(negedge CLK);
    a_mem_gnt = 1'b0;
  endtask

  task automatic a_check_req(input string name, input logic [A_ADDR_W-1:0] addr,
                             input logic [A_WORD_W-1:0] wdata);
    checks++;
    if (a_mem_we !== 1'b1 || a_mem_addr !== addr || a_mem_wdata !== wdata) begin
      errors++;
      $display("[TB] FAIL %s: we/addr/wdata got %b/%h/%h want 1/%h/%h",
               name, a_mem_we, a_mem_addr, a_mem_wdata, addr, wdata);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (a_mem_req !== 1'b0 || a_mem_we !== 1'b0 || a_mem_addr !== '0 || a_mem_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mem: req/we/addr/wdata got %b/%b/%h/%h want all zero",
               a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    checks++;
    if (a_scan_out !== 1'b0 || a_init_done !== 1'b0 || a_frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: scanOut/init_done/frame_err got %b/%b/%b want 0/0/0",
               a_scan_out, a_init_done, a_frame_err);
    end
    checks++;
    if (b_mem_req !== 1'b0 || b_scan_out !== 4'h0 || b_frame_err !== 1'b0 || b_init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: req/scanOut/frame_err/init_done got %b/%h/%b/%b want 0/0/0/0",
               b_mem_req, b_scan_out, b_frame_err, b_init_done);
    end
  endtask

  task automatic test_write();
    int hs0 = a_hs;
    a_send({1'b1, 8'h21, 64'h0000_0000_0302_0100}, 73);
    repeat (3) @(negedge CLK);
    checks++;
    if (a_mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_latency_early: mem_req got %b want 0", a_mem_req);
    end
    @(negedge CLK);
    checks++;
    if (a_mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_latency: mem_req got %b want 1", a_mem_req);
    end
    a_check_req("write_fields", 8'h21, 64'h0000_0000_0302_0100);
    a_grant();
    checks++;
    if (a_mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_release: mem_req got %b want 0", a_mem_req);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (a_hs - hs0 != 1) begin
      errors++;
      $display("[TB] FAIL write_count: handshakes got %0d want 1", a_hs - hs0);
    end
  endtask

  task automatic test_back_pressure();
    int hs0 = a_hs;
    a_send({1'b1, 8'hA5, 64'hDEAD_BEEF_1234_5678}, 73);
    a_wait_req("bp_req");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_mem_req !== 1'b1 || a_mem_addr !== 8'hA5 || a_mem_wdata !== 64'hDEAD_BEEF_1234_5678) begin
        errors++;
        $display("[TB] FAIL bp_stable[%0d]: req/addr/wdata got %b/%h/%h want 1/a5/deadbeef12345678",
                 i, a_mem_req, a_mem_addr, a_mem_wdata);
      end
      @(negedge CLK);
    end
    a_grant();
    repeat (10) @(negedge CLK);
    checks++;
    if (a_hs - hs0 != 1 || a_mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_single: handshakes/req got %0d/%b want 1/0", a_hs - hs0, a_mem_req);
    end
  endtask

  task automatic test_bad_length();
    int rc0 = a_req_cycles;
    a_send({1'b1, 8'h33, 64'h1111_2222_3333_4444}, 72);
    repeat (8) @(negedge CLK);
    checks++;
    if (a_frame_err !== 1'b1 || a_req_cycles != rc0) begin
      errors++;
      $display("[TB] FAIL bad_length: frame_err/req_cycles got %b/%0d want 1/0",
               a_frame_err, a_req_cycles - rc0);
    end
    a_send({1'b1, 8'h5A, 64'h0000_0000_CAFE_F00D}, 73);
    a_wait_req("bad_length_next_req");
    a_check_req("bad_length_next", 8'h5A, 64'h0000_0000_CAFE_F00D);
    a_grant();
    checks++;
    if (a_frame_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_err_sticky: got %b want 1", a_frame_err);
    end
  endtask

  task automatic test_reset_mid();
    int hs0;
    a_sc_en = 1'b1;
    repeat (3) @(negedge CLK);
    a_shift({1'b1, 8'h77, 64'h0123_4567_89AB_CDEF}, 20);
    RESET = 1'b1;
    a_sc_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (a_frame_err !== 1'b0 || a_mem_req !== 1'b0 || a_scan_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_shift: frame_err/req/scanOut got %b/%b/%b want 0/0/0",
               a_frame_err, a_mem_req, a_scan_out);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    a_send({1'b1, 8'hC3, 64'hFEDC_BA98_7654_3210}, 73);
    a_wait_req("reset_req_pre");
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (a_mem_req !== 1'b0 || a_mem_we !== 1'b0 || a_mem_addr !== '0 || a_mem_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req: req/we/addr/wdata got %b/%b/%h/%h want all zero",
               a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    hs0 = a_hs;
    a_send({1'b1, 8'h3C, 64'h0F0F_0F0F_A5A5_5A5A}, 73);
    a_wait_req("reset_clean_req");
    a_check_req("reset_clean", 8'h3C, 64'h0F0F_0F0F_A5A5_5A5A);
    a_grant();
    repeat (2) @(negedge CLK);
    checks++;
    if (a_hs - hs0 != 1) begin
      errors++;
      $display("[TB] FAIL reset_clean_count: handshakes got %0d want 1", a_hs - hs0);
    end
  endtask

  task automatic test_sentinel();
    int rc0 = a_req_cycles;
    logic [72:0] ones = '1;
    a_send(ones, 73);
    repeat (8) @(negedge CLK);
    checks++;
    if (a_init_done !== 1'b1 || a_req_cycles != rc0) begin
      errors++;
      $display("[TB] FAIL sentinel: init_done/req_cycles got %b/%0d want 1/0",
               a_init_done, a_req_cycles - rc0);
    end
    a_send({1'b1, 8'h44, 64'h0000_0000_0000_0044}, 73);
    repeat (10) @(negedge CLK);
    checks++;
    if (a_req_cycles != rc0 || a_init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_ignores: req_cycles/init_done got %0d/%b want 0/1",
               a_req_cycles - rc0, a_init_done);
    end
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (a_init_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_reset: init_done got %b want 0", a_init_done);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_readback();
    logic [43:0] rd_frame = {1'b0, 11'h031, 32'h0000_0000};
    logic [43:0] wr_frame = {1'b1, 11'h123, 32'h89AB_CDEF};
    logic [3:0]  exp_nib [11] = '{4'h4, 4'h0, 4'h5, 4'h0, 4'h6, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    int t;
    b_sc_en = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      b_scan_in = rd_frame[i*4 +: 4];
      b_sc_clk = 1'b0;
      repeat (3) @(negedge CLK);
      b_sc_clk = 1'b1;
      repeat (3) @(negedge CLK);
    end
    b_sc_clk = 1'b0;
    b_sc_en = 1'b0;
    t = 0;
    while (b_mem_req !== 1'b1 && t < 40) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (b_mem_req !== 1'b1 || b_mem_we !== 1'b0 || b_mem_addr !== 11'h031) begin
      errors++;
      $display("[TB] FAIL rd_req: req/we/addr got %b/%b/%h want 1/0/031", b_mem_req, b_mem_we, b_mem_addr);
    end
    b_mem_gnt = 1'b1;
    @(negedge CLK);
    b_mem_gnt = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    b_mem_rdata = 32'hFF06_0504;
    b_mem_rvalid = 1'b1;
    @(negedge CLK);
    b_mem_rvalid = 1'b0;
    b_mem_rdata = '0;
    repeat (2) @(negedge CLK);
    b_sc_en = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (b_scan_out !== exp_nib[i]) begin
        errors++;
        $display("[TB] FAIL readback[%0d]: scanOut got %h want %h", i, b_scan_out, exp_nib[i]);
      end
      b_scan_in = wr_frame[i*4 +: 4];
      b_sc_clk = 1'b0;
      repeat (3) @(negedge CLK);
      b_sc_clk = 1'b1;
      repeat (3) @(negedge CLK);
    end
    b_sc_clk = 1'b0;
    b_sc_en = 1'b0;
    t = 0;
    while (b_mem_req !== 1'b1 && t < 40) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (b_mem_req !== 1'b1 || b_mem_we !== 1'b1 || b_mem_addr !== 11'h123 || b_mem_wdata !== 32'h89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL lanes4_write: req/we/addr/wdata got %b/%b/%h/%h want 1/1/123/89abcdef",
               b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata);
    end
    b_mem_gnt = 1'b1;
    @(negedge CLK);
    b_mem_gnt = 1'b0;
    checks++;
    if (b_frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lanes4_no_err: frame_err got %b want 0", b_frame_err);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog timeout");
  end

  initial begin
    $display("[TB] starting scan_sram_loader bench");
    test_reset();
    test_write();
    test_back_pressure();
    test_bad_length();
    test_reset_mid();
    test_sentinel();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
